// File: rtl/button_mode_controller_if.sv
// Front-panel bundle between the four button press detectors / counters and the mode controller.
// master = panel/detector side, slave = button_mode_controller.
interface button_mode_controller_if;
  logic       press_mode;
  logic       press_alarm;
  logic       press_inc;
  logic       press_dec;
  logic [3:0] det_clr_n;
  logic [2:0] mode;
  logic       target_alarm;
  logic       adj_hr_up;
  logic       adj_hr_dn;
  logic       adj_min_up;
  logic       adj_min_dn;
  logic       blink;

  modport master (
    output press_mode, press_alarm, press_inc, press_dec,
    input  det_clr_n, mode, target_alarm,
    input  adj_hr_up, adj_hr_dn, adj_min_up, adj_min_dn, blink
  );

  modport slave (
    input  press_mode, press_alarm, press_inc, press_dec,
    output det_clr_n, mode, target_alarm,
    output adj_hr_up, adj_hr_dn, adj_min_up, adj_min_dn, blink
  );
endinterface

// File: rtl/button_mode_controller.sv
// Alarm-clock front-panel sequencer: press arbitration, set-time/set-alarm mode FSM, adjust strobes, blink.
// Optional `define MODE_TIMEOUT_EN adds an idle counter that returns non-RUN states to RUN.
module button_mode_controller #(
  parameter int unsigned BLINK_CYCLES   = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter int unsigned CNT_W          = 28
) (
  input  logic clk,
  input  logic resetn,
  button_mode_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_ALM_HR  = 3'd3,
    ST_ALM_MIN = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_BLINK_MAX = CNT_W'(BLINK_CYCLES - 1);

  if (BLINK_CYCLES < 2 || TIMEOUT_CYCLES < 2 || CNT_W < 1) begin : g_bad_params
    $error("button_mode_controller: BLINK_CYCLES/TIMEOUT_CYCLES must be >= 2");
  end

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_det_clr_n;
  logic [3:0]       r_adj;
  logic [3:0]       w_adj;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink;

  logic w_acc_mode;
  logic w_acc_alarm;
  logic w_acc_inc;
  logic w_acc_dec;
  logic w_acc_any;
  logic w_in_hr;
  logic w_in_min;
  logic w_state_chg;

  // Fixed priority mode > alarm > inc > dec; losers are simply dropped.
  assign w_acc_mode  = bus.press_mode;
  assign w_acc_alarm = bus.press_alarm & ~bus.press_mode;
  assign w_acc_inc   = bus.press_inc & ~bus.press_alarm & ~bus.press_mode;
  assign w_acc_dec   = bus.press_dec & ~bus.press_inc & ~bus.press_alarm & ~bus.press_mode;
  assign w_acc_any   = w_acc_mode | w_acc_alarm | w_acc_inc | w_acc_dec;

  assign w_in_hr     = (r_state == ST_SET_HR)  || (r_state == ST_ALM_HR);
  assign w_in_min    = (r_state == ST_SET_MIN) || (r_state == ST_ALM_MIN);
  assign w_state_chg = (w_next != r_state);

`ifdef MODE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LP_TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_idle_cnt;
  logic             w_timeout;

  assign w_timeout = (r_state != ST_RUN) && !w_acc_any && (r_idle_cnt == LP_TIMEOUT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idle_cnt <= '0;
    end else if (w_state_chg || w_acc_any || (r_state == ST_RUN)) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + LP_ONE;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_adj  = 4'b0000;
    case (r_state)
      ST_RUN: begin
        if (w_acc_mode)       w_next = ST_SET_HR;
        else if (w_acc_alarm) w_next = ST_ALM_HR;
      end
      ST_SET_HR: begin
        if (w_acc_mode) w_next = ST_SET_MIN;
      end
      ST_SET_MIN: begin
        if (w_acc_mode) w_next = ST_RUN;
      end
      ST_ALM_HR: begin
        if (w_acc_alarm)     w_next = ST_ALM_MIN;
        else if (w_acc_mode) w_next = ST_RUN;
      end
      ST_ALM_MIN: begin
        if (w_acc_alarm || w_acc_mode) w_next = ST_RUN;
      end
      default: w_next = ST_RUN;
    endcase
`ifdef MODE_TIMEOUT_EN
    if (w_timeout) w_next = ST_RUN;
`endif
    // Strobe order {min_dn, min_up, hr_dn, hr_up}; arbitration guarantees one-hot.
    w_adj[0] = w_in_hr  & w_acc_inc;
    w_adj[1] = w_in_hr  & w_acc_dec;
    w_adj[2] = w_in_min & w_acc_inc;
    w_adj[3] = w_in_min & w_acc_dec;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_det_clr_n <= 4'b0000;
      r_adj       <= 4'b0000;
    end else begin
      r_det_clr_n <= ~{w_acc_dec, w_acc_inc, w_acc_alarm, w_acc_mode};
      r_adj       <= w_adj;
    end
  end

  // Restart from the visible phase on every state change and every adjust press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_state_chg || w_acc_inc || w_acc_dec || (r_state == ST_RUN)) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == LP_BLINK_MAX) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + LP_ONE;
    end
  end

  assign bus.det_clr_n    = r_det_clr_n;
  assign bus.mode         = r_state;
  assign bus.target_alarm = (r_state == ST_ALM_HR) || (r_state == ST_ALM_MIN);
  assign bus.adj_hr_up    = r_adj[0];
  assign bus.adj_hr_dn    = r_adj[1];
  assign bus.adj_min_up   = r_adj[2];
  assign bus.adj_min_dn   = r_adj[3];
  assign bus.blink        = r_blink;

endmodule
